// File: rtl/mem_access_if.sv
// mem_access_if: memory-op/writeback types and the data-memory request bus
package mem_access_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rdAddr;
    logic [2:0]  opType;
    logic        read;
    logic        write;
  } tMemOp;

  typedef struct packed {
    logic        dv;
    logic [4:0]  addr;
    logic [31:0] data;
  } tRegOp;
endpackage

interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wData;
  logic [3:0]  be;
  logic        gnt;
  logic        rValid;
  logic [31:0] rData;
  modport master (output req, we, addr, wData, be, input gnt, rValid, rData);
  modport slave (input req, we, addr, wData, be, output gnt, rValid, rData);
endinterface

// File: rtl/mem_access.sv
// mem_access: load/store unit turning ALU memory ops into req/gnt data-memory transactions
module mem_access
  import mem_access_pkg::*;
#(
  parameter int pTimeout = 255
) (
  input  logic         iClk,
  input  logic         iRst,
  input  tMemOp        iMemOp,
  mem_access_if.master dmem,
  output tRegOp        oRegWB,
  output logic         oBusy,
  output logic         oMisalign,
  output logic         oBusErr
);
  localparam int cntW = $clog2(pTimeout + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} tState;

  tState           state, nextState;
  logic [cntW-1:0] cnt;
  logic [1:0]      addrLo;
  logic [2:0]      opR;
  logic [4:0]      rdR;
  logic            isLoad, isStore, legalOp, aligned, accept, reject;
  logic            expire, busErrNext, wbFire;
  logic [3:0]      beNext;
  logic [31:0]     wDataNext, shifted, loadData;

  assign dmem.req = state == REQ;
  assign oBusy    = state != IDLE;

  // decode the incoming op: legality, alignment, lane enables and replicated store data
  always_comb begin
    isLoad    = iMemOp.read & ~iMemOp.write;
    isStore   = iMemOp.write & ~iMemOp.read;
    legalOp   = isLoad ? (iMemOp.opType inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) :
                isStore ? (iMemOp.opType inside {3'b000, 3'b001, 3'b010}) : 1'b0;
    aligned   = (iMemOp.opType[1:0] == 2'b00) |
                ((iMemOp.opType[1:0] == 2'b01) & ~iMemOp.addr[0]) |
                (iMemOp.addr[1:0] == 2'b00);
    accept    = (state == IDLE) & legalOp & aligned;
    reject    = (state == IDLE) & (iMemOp.read | iMemOp.write) & ~(legalOp & aligned);
    beNext    = iMemOp.opType[1] ? 4'b1111 :
                iMemOp.opType[0] ? 4'b0011 << iMemOp.addr[1:0] : 4'b0001 << iMemOp.addr[1:0];
    wDataNext = iMemOp.opType[1] ? iMemOp.data :
                iMemOp.opType[0] ? {2{iMemOp.data[15:0]}} : {4{iMemOp.data[7:0]}};
  end

  // pick the addressed lane out of the returned word and sign/zero extend it
  always_comb begin
    shifted  = dmem.rData >> {addrLo, 3'b000};
    loadData = opR[1] ? shifted :
               opR[0] ? {{16{~opR[2] & shifted[15]}}, shifted[15:0]} :
                        {{24{~opR[2] & shifted[7]}}, shifted[7:0]};
  end

  // next state; a grant or read-valid in the expiry cycle counts as progress
  always_comb begin
    nextState  = state;
    expire     = cnt == cntW'(pTimeout - 1);
    busErrNext = 1'b0;
    wbFire     = 1'b0;
    case (state)
      IDLE: nextState = accept ? REQ : IDLE;
      REQ: begin
        nextState  = dmem.gnt ? (dmem.we ? IDLE : WAIT) : expire ? IDLE : REQ;
        busErrNext = ~dmem.gnt & expire;
      end
      WAIT: begin
        nextState  = (dmem.rValid | expire) ? IDLE : WAIT;
        busErrNext = ~dmem.rValid & expire;
        wbFire     = dmem.rValid & |rdR;
      end
      default: nextState = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) state <= IDLE;
    else state <= nextState;

  // timeout counter restarts whenever REQ or WAIT is entered
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) cnt <= '0;
    else cnt <= (state == IDLE || nextState != state) ? '0 : cnt + cntW'(1);

  // request fields captured on accept and held stable until the next accepted op
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.wData <= '0;
      dmem.be    <= '0;
      addrLo     <= '0;
      opR        <= '0;
      rdR        <= '0;
    end else if (accept) begin
      dmem.we    <= isStore;
      dmem.addr  <= {iMemOp.addr[31:2], 2'b00};
      dmem.wData <= wDataNext;
      dmem.be    <= beNext;
      addrLo     <= iMemOp.addr[1:0];
      opR        <= iMemOp.opType;
      rdR        <= iMemOp.rdAddr;
    end

  // one-cycle status pulses and load writeback; writeback address/data hold between pulses
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      oMisalign <= 1'b0;
      oBusErr   <= 1'b0;
      oRegWB    <= '0;
    end else begin
      oMisalign <= reject;
      oBusErr   <= busErrNext;
      oRegWB.dv <= wbFire;
      if (wbFire) begin
        oRegWB.addr <= rdR;
        oRegWB.data <= loadData;
      end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized load/store traffic against a byte-lane memory model
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 4;

  logic  iClk = 1'b0;
  logic  iRst = 1'b0;
  tMemOp iMemOp;
  tRegOp oRegWB;
  logic  oBusy, oMisalign, oBusErr;

  mem_access_if bus();

  mem_access #(.pTimeout(TO)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .iMemOp(iMemOp),
    .dmem(bus),
    .oRegWB(oRegWB),
    .oBusy(oBusy),
    .oMisalign(oMisalign),
    .oBusErr(oBusErr)
  );

  always #5 iClk = ~iClk;

  int          nVec = 0;
  int          nErr = 0;
  logic [31:0] mem [int];
  logic [4:0]  wbAddr = '0;
  logic [31:0] wbData = '0;
  logic [31:0] lastAddr, lastWd, lastData;
  logic [3:0]  lastBe;
  logic        lastBusErr;
  logic [2:0]  lops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memRd(int w);
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  function automatic tMemOp junkOp(bit act);
    tMemOp m;
    m.addr   = $urandom;
    m.data   = $urandom;
    m.rdAddr = 5'($urandom);
    m.opType = 3'($urandom);
    m.read   = act & 1'($urandom);
    m.write  = act & 1'($urandom);
    return m;
  endfunction

  function automatic logic [31:0] loadVal(logic [31:0] word, logic [1:0] a, logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> (8 * a));
    h = 16'(word >> (8 * a));
    case (op)
      3'd0: return 32'($signed(b));
      3'd1: return 32'($signed(h));
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return word;
    endcase
  endfunction

  task automatic checkZero(input string tag);
    check({tag, "Req"}, bus.req, 0);
    check({tag, "We"}, bus.we, 0);
    check({tag, "Addr"}, bus.addr, 0);
    check({tag, "WData"}, bus.wData, 0);
    check({tag, "Be"}, bus.be, 0);
    check({tag, "RegWB"}, oRegWB, 0);
    check({tag, "Misalign"}, oMisalign, 0);
    check({tag, "BusErr"}, oBusErr, 0);
    check({tag, "Busy"}, oBusy, 0);
  endtask

  // present one op at a negedge in IDLE, play the memory side, check every cycle until IDLE again
  task automatic doOp(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] rdA, input logic [2:0] op, input int gDly, input int rDly);
    int          sz, w;
    bit          legal, ok, granted, got;
    logic [3:0]  eBe;
    logic [31:0] eWd, word, v;
    sz    = 1 << op[1:0];
    w     = int'(a >> 2);
    legal = (rd != wr) && (rd ? (op inside {0, 1, 2, 4, 5}) : (op inside {0, 1, 2}));
    ok    = legal && (a % sz == 0);
    eBe   = 4'(((1 << sz) - 1) << a[1:0]);
    for (int i = 0; i < 4; i++) eWd[8*i +: 8] = d[8*(i % sz) +: 8];
    lastBusErr = 1'b0;
    check("idleBefore", oBusy, 0);
    iMemOp = '{addr: a, data: d, rdAddr: rdA, opType: op, read: rd, write: wr};
    @(negedge iClk);
    iMemOp = junkOp(0);
    check("misalign", oMisalign, ok ? 1'b0 : (rd | wr));
    if (!ok) begin
      check("rejNoReq", bus.req, 0);
      check("rejBusy", oBusy, 0);
      @(negedge iClk);
      check("misalignPulse", oMisalign, 0);
      check("rejNoReq2", bus.req, 0);
      return;
    end
    lastAddr = bus.addr;
    lastBe   = bus.be;
    lastWd   = bus.wData;
    granted  = 1'b0;
    for (int k = 0; k < TO && !granted; k++) begin
      check("req", bus.req, 1);
      check("reqBusy", oBusy, 1);
      check("we", bus.we, wr);
      check("addr", bus.addr, a & ~32'd3);
      check("be", bus.be, eBe);
      if (wr) check("wData", bus.wData, eWd);
      bus.gnt    = (k == gDly);
      bus.rValid = 1'($urandom_range(0, 1));
      bus.rData  = $urandom;
      iMemOp     = junkOp(1);
      @(negedge iClk);
      bus.gnt    = 1'b0;
      bus.rValid = 1'b0;
      iMemOp     = junkOp(0);
      granted    = (k == gDly);
    end
    if (!granted) begin
      check("reqTimeout", oBusErr, 1);
      check("reqTimeoutNoReq", bus.req, 0);
      check("reqTimeoutIdle", oBusy, 0);
      check("reqTimeoutNoWb", oRegWB.dv, 0);
      lastBusErr = oBusErr;
      @(negedge iClk);
      check("busErrPulse", oBusErr, 0);
      return;
    end
    if (wr) begin
      check("storeReqDrop", bus.req, 0);
      check("storeIdle", oBusy, 0);
      check("storeNoWb", oRegWB.dv, 0);
      check("storeNoErr", oBusErr, 0);
      word = memRd(w);
      for (int i = 0; i < 4; i++) if (eBe[i]) word[8*i +: 8] = eWd[8*i +: 8];
      mem[w] = word;
      return;
    end
    word = memRd(w);
    got  = 1'b0;
    for (int j = 0; j < TO && !got; j++) begin
      check("waitNoReq", bus.req, 0);
      check("waitBusy", oBusy, 1);
      check("waitNoWb", oRegWB.dv, 0);
      bus.rValid = (j == rDly);
      bus.rData  = (j == rDly) ? word : $urandom;
      bus.gnt    = 1'($urandom_range(0, 1));
      iMemOp     = junkOp(1);
      @(negedge iClk);
      bus.rValid = 1'b0;
      bus.gnt    = 1'b0;
      iMemOp     = junkOp(0);
      got        = (j == rDly);
    end
    if (got) begin
      v        = loadVal(word, a[1:0], op);
      lastData = v;
      if (rdA != 0) begin
        wbAddr = rdA;
        wbData = v;
      end
      check("wbDv", oRegWB.dv, rdA != 0);
      check("loadNoErr", oBusErr, 0);
    end else begin
      check("waitTimeout", oBusErr, 1);
      check("waitTimeoutNoWb", oRegWB.dv, 0);
      lastBusErr = oBusErr;
    end
    check("loadIdle", oBusy, 0);
    check("wbAddr", oRegWB.addr, wbAddr);
    check("wbData", oRegWB.data, wbData);
    @(negedge iClk);
    check("wbPulse", oRegWB.dv, 0);
    check("errPulse", oBusErr, 0);
    check("wbHoldAddr", oRegWB.addr, wbAddr);
    check("wbHoldData", oRegWB.data, wbData);
  endtask

  initial begin
    int          r, gD, rD;
    logic        rd, wr;
    logic [2:0]  op;
    logic [31:0] a;
    logic [4:0]  rdA;
    bus.gnt    = 1'b0;
    bus.rValid = 1'b0;
    bus.rData  = '0;
    iMemOp     = '0;
    #2 iRst = 1'b1;
    #1 checkZero("rst0");
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);

    mem[32'h100 >> 2] = 32'h80FF_0000;
    doOp(1, 0, 32'h103, 32'h0, 5'd5, 3'd0, 0, 0);
    check("lbBe", lastBe, 4'b1000);
    check("lbData", lastData, 32'hFFFF_FF80);

    doOp(0, 1, 32'h202, 32'h1234_ABCD, 5'd0, 3'd1, 0, 0);
    check("shAddr", lastAddr, 32'h200);
    check("shBe", lastBe, 4'b1100);
    check("shWData", lastWd, 32'hABCD_ABCD);

    doOp(1, 0, 32'h101, 32'h0, 5'd3, 3'd2, 0, 0);

    doOp(1, 0, 32'h100, 32'h0, 5'd7, 3'd2, 0, 99);
    check("loadTimeoutErr", lastBusErr, 1);

    doOp(0, 1, 32'h104, 32'hCAFE_F00D, 5'd0, 3'd2, TO - 1, 0);
    check("gntAtExpiryNoErr", lastBusErr, 0);

    mem[32'h306 >> 2] = 32'hF00D_1234;
    doOp(1, 0, 32'h306, 32'h0, 5'd9, 3'd5, 1, 2);
    check("lhuData", lastData, 32'h0000_F00D);

    iMemOp = '{addr: 32'h104, data: 32'h0, rdAddr: 5'd3, opType: 3'd2, read: 1'b1, write: 1'b0};
    @(negedge iClk);
    iMemOp  = junkOp(0);
    bus.gnt = 1'b1;
    @(negedge iClk);
    bus.gnt = 1'b0;
    check("rstWaitBusy", oBusy, 1);
    #2 iRst = 1'b1;
    #1 checkZero("rstMid");
    @(negedge iClk);
    iRst   = 1'b0;
    wbAddr = '0;
    wbData = '0;
    repeat (2) @(negedge iClk);
    bus.rValid = 1'b1;
    bus.rData  = $urandom;
    @(negedge iClk);
    bus.rValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstNoWb", oRegWB.dv, 0);
      check("rstIdle", oBusy, 0);
      @(negedge iClk);
    end

    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 19);
      rd = (r < 9) || (r == 18);
      wr = (r >= 9 && r < 18) || (r == 18);
      if ($urandom_range(0, 3) == 0) op = 3'($urandom);
      else op = rd ? lops[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = 32'h100 + $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      rdA = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      gD  = $urandom_range(0, TO + 1);
      rD  = $urandom_range(0, TO + 1);
      doOp(rd, wr, a, $urandom, rdA, op, gD, rD);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
